// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/AND/OR plus an iterative radix-2 shift-add multiplier (MUL/UMULL/SMULL).
// Optional macro ALU_MC_EARLY_TERM_EN: leave the multiply loop once the remaining multiplier is zero.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic [3:0]       ALUFlags
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_UMULL = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b110;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   sign_q, sign_d;
    logic [2:0]             op_q, op_d;
    logic [WIDTH-1:0]       r1_q, r1_d;
    logic [WIDTH-1:0]       r2_q, r2_d;
    logic [3:0]             flags_q, flags_d;
    logic                   done_q, done_d;

    // Single-cycle datapath
    logic [WIDTH-1:0]       b_sel;
    logic [WIDTH:0]         sum;
    logic                   sum_v;
    logic                   is_mul_op;
    logic                   is_smull;
    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;

    assign b_sel     = ALUControl[0] ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, ALUControl[0]};
    assign sum_v     = (sum[WIDTH-1] ^ a[WIDTH-1]) & ~(ALUControl[0] ^ a[WIDTH-1] ^ b[WIDTH-1]);
    assign is_mul_op = (ALUControl == OP_MUL) || (ALUControl == OP_UMULL) || (ALUControl == OP_SMULL);
    assign is_smull  = (ALUControl == OP_SMULL);
    assign abs_a     = (is_smull && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b     = (is_smull && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Multiplier iteration datapath
    logic [2*WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       mplier_shift;
    logic                   last_iter;

    assign addend       = mplier_q[0] ? mcand_q : '0;
    assign acc_step     = acc_q + addend;
    assign product      = sign_q ? (~acc_step + 1'b1) : acc_step;
    assign mplier_shift = mplier_q >> 1;

`ifdef ALU_MC_EARLY_TERM_EN
    // Remaining multiplier bits all zero means the accumulator already holds the product.
    assign last_iter = (count_q == CW'(1)) || (mplier_shift == '0);
`else
    assign last_iter = (count_q == CW'(1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        sign_d   = sign_q;
        op_d     = op_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        flags_d  = flags_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul_op) begin
                        state_d  = MUL;
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                        acc_d    = '0;
                        count_d  = CW'(WIDTH);
                        sign_d   = is_smull & (a[WIDTH-1] ^ b[WIDTH-1]);
                        op_d     = ALUControl;
                    end else begin
                        done_d = 1'b1;
                        r2_d   = '0;
                        case (ALUControl)
                            3'b000, 3'b001: begin
                                r1_d    = sum[WIDTH-1:0];
                                flags_d = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), sum[WIDTH], sum_v};
                            end
                            OP_AND: begin
                                r1_d    = a & b;
                                flags_d = {r1_d[WIDTH-1], (r1_d == '0), 2'b00};
                            end
                            OP_OR: begin
                                r1_d    = a | b;
                                flags_d = {r1_d[WIDTH-1], (r1_d == '0), 2'b00};
                            end
                            default: begin
                                r1_d    = '0;
                                flags_d = 4'b0000;
                            end
                        endcase
                    end
                end
            end

            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                count_d  = count_q - CW'(1);
                if (last_iter) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    r1_d    = product[WIDTH-1:0];
                    r2_d    = (op_q == OP_MUL) ? '0 : product[2*WIDTH-1:WIDTH];
                    flags_d = {r1_d[WIDTH-1], (r1_d == '0), 2'b00};
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            op_q     <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            op_q     <= op_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == MUL);
    assign done     = done_q;
    assign Result1  = r1_q;
    assign Result2  = r2_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results/latency queued at launch, compared when done pulses.
module tb_alu_mc;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    ALUControl;
    logic          busy;
    logic          done;
    logic [W-1:0]  Result1;
    logic [W-1:0]  Result2;
    logic [3:0]    ALUFlags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [3:0]   fl;
        int           lat;
        int           bsy;
    } exp_t;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [3:0]   fl;
        int           lat;
        int           bsy;
        bit           to;
    } obs_t;

    exp_t sb[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .busy       (busy),
        .done       (done),
        .Result1    (Result1),
        .Result2    (Result2),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        exp_t        e;
        logic [W:0]  s;
        logic [63:0] p;
        longint      sx;
        longint      sy;
        logic [W-1:0] mb;
        int          k;
        e.r1 = '0; e.r2 = '0; e.fl = '0; e.lat = 1; e.bsy = 0;
        p = '0;
        case (op)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                e.r1 = s[W-1:0];
                e.fl = {s[W-1], (s[W-1:0] == 0), s[W], (x[W-1] == y[W-1]) && (s[W-1] != x[W-1])};
            end
            3'd1: begin
                e.r1 = x - y;
                e.fl = {e.r1[W-1], (e.r1 == 0), (x >= y), (x[W-1] != y[W-1]) && (e.r1[W-1] != x[W-1])};
            end
            3'd2: begin e.r1 = x & y; e.fl = {e.r1[W-1], (e.r1 == 0), 2'b00}; end
            3'd3: begin e.r1 = x | y; e.fl = {e.r1[W-1], (e.r1 == 0), 2'b00}; end
            3'd7: ;
            default: begin
                if (op == 3'd6) begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    p  = 64'(sx * sy);
                end else begin
                    p = {32'b0, x} * {32'b0, y};
                end
                e.r1 = p[W-1:0];
                e.r2 = (op == 3'd4) ? '0 : p[63:32];
                e.fl = {e.r1[W-1], (e.r1 == 0), 2'b00};
`ifdef ALU_MC_EARLY_TERM_EN
                mb = (op == 3'd6 && y[W-1]) ? (~y + 1'b1) : y;
                k = 1;
                for (int i = 0; i < W; i++) if (mb[i]) k = i + 1;
`else
                mb = y;
                k  = W;
`endif
                e.lat = k + 1;
                e.bsy = k;
            end
        endcase
        return e;
    endfunction

    // Drive one start pulse and queue its expected outcome; returns one cycle after the start edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        a = x; b = y; ALUControl = op; start = 1'b1;
        sb.push_back(model(x, y, op));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; ALUControl = 3'($urandom_range(0, 7));
    endtask

    // Waits (bounded) for done, reporting latency and busy cycles; performs no comparison itself.
    task automatic collect(output obs_t o);
        o.lat = 1; o.bsy = 0; o.to = 1'b0;
        while (!done) begin
            if (busy) o.bsy++;
            if (o.lat > 200) begin
                o.to = 1'b1;
                break;
            end
            @(posedge clk); #1;
            o.lat++;
        end
        o.r1 = Result1; o.r2 = Result2; o.fl = ALUFlags;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; ALUControl = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (Result1 !== '0) begin errors++; $display("FAIL reset_r1 got %h want 0", Result1); end
        checks++; if (Result2 !== '0) begin errors++; $display("FAIL reset_r2 got %h want 0", Result2); end
        checks++; if (ALUFlags !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", ALUFlags); end
        $display("reset: busy=%b done=%b r1=%h r2=%h flags=%b", busy, done, Result1, Result2, ALUFlags);
    endtask

    task automatic test_single_cycle;
        logic [W-1:0] va [8] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h12345678, 32'hF0F0F0F0, 32'h0000FF00, 32'hDEADBEEF, 32'h7FFFFFFF};
        logic [W-1:0] vb [8] = '{32'h00000001, 32'd7, 32'h00000001, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h00FF0000, 32'h12345678, 32'h00000001};
        logic [2:0]   vo [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd7, 3'd0};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            launch(va[i], vb[i], vo[i]);
            collect(o);
            e = sb.pop_front();
            $display("single op=%0d a=%h b=%h -> r1=%h r2=%h f=%b lat=%0d", vo[i], va[i], vb[i], o.r1, o.r2, o.fl, o.lat);
            checks++;
            if (o.to || o.lat != e.lat || o.bsy != 0) begin
                errors++;
                $display("FAIL single_timing[%0d] got lat=%0d busy=%0d to=%0b want lat=%0d busy=0", i, o.lat, o.bsy, o.to, e.lat);
            end
            checks++;
            if (o.r1 !== e.r1 || o.r2 !== e.r2 || o.fl !== e.fl) begin
                errors++;
                $display("FAIL single_result[%0d] got r1=%h r2=%h f=%b want r1=%h r2=%h f=%b", i, o.r1, o.r2, o.fl, e.r1, e.r2, e.fl);
            end
        end
    endtask

    task automatic test_multiply;
        logic [W-1:0] va [9] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00010000, 32'd7, 32'd5, 32'h80000000, 32'h12345678, 32'hFFFFFF85, 32'h00000003};
        logic [W-1:0] vb [9] = '{32'hFFFFFFFF, 32'h00000003, 32'h00010000, 32'd3, 32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'h00001234, 32'h80000000};
        logic [2:0]   vo [9] = '{3'd5, 3'd6, 3'd4, 3'd4, 3'd4, 3'd6, 3'd5, 3'd6, 3'd6};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            launch(va[i], vb[i], vo[i]);
            collect(o);
            e = sb.pop_front();
            $display("mul op=%0d a=%h b=%h -> r2=%h r1=%h f=%b lat=%0d busy=%0d", vo[i], va[i], vb[i], o.r2, o.r1, o.fl, o.lat, o.bsy);
            checks++;
            if (o.to || o.lat != e.lat || o.bsy != e.bsy) begin
                errors++;
                $display("FAIL mul_timing[%0d] got lat=%0d busy=%0d to=%0b want lat=%0d busy=%0d", i, o.lat, o.bsy, o.to, e.lat, e.bsy);
            end
            checks++;
            if (o.r1 !== e.r1 || o.r2 !== e.r2 || o.fl !== e.fl) begin
                errors++;
                $display("FAIL mul_result[%0d] got r1=%h r2=%h f=%b want r1=%h r2=%h f=%b", i, o.r1, o.r2, o.fl, e.r1, e.r2, e.fl);
            end
        end
    endtask

    // Each op is launched in the very cycle the previous done is visible.
    task automatic test_back_to_back;
        logic [W-1:0] va [4] = '{32'd1234, 32'h7FFFFFFF, 32'hFFFFFFF9, 32'hAAAA5555};
        logic [W-1:0] vb [4] = '{32'd4321, 32'h00000001, 32'h00000009, 32'h0000FFFF};
        logic [2:0]   vo [4] = '{3'd4, 3'd0, 3'd6, 3'd3};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], vo[i]);
            collect(o);
            e = sb.pop_front();
            $display("b2b op=%0d a=%h b=%h -> r2=%h r1=%h f=%b lat=%0d", vo[i], va[i], vb[i], o.r2, o.r1, o.fl, o.lat);
            checks++;
            if (o.to || o.lat != e.lat || o.r1 !== e.r1 || o.r2 !== e.r2 || o.fl !== e.fl) begin
                errors++;
                $display("FAIL b2b[%0d] got r1=%h r2=%h f=%b lat=%0d want r1=%h r2=%h f=%b lat=%0d", i, o.r1, o.r2, o.fl, o.lat, e.r1, e.r2, e.fl, e.lat);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || Result1 !== e.r1) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b r1=%h want done=0 r1=%h", done, Result1, e.r1);
        end
    endtask

    task automatic test_busy_restart;
`ifdef ALU_MC_EARLY_TERM_EN
        localparam int RP = 1;
`else
        localparam int RP = 5;
`endif
        int   c;
        int   extra;
        exp_t e;
        launch(32'd7, 32'd3, 3'd4);
        c = 1;
        while (!done && c < 200) begin
            if (c == RP) begin
                start = 1'b1; a = 32'd9; b = 32'd9; ALUControl = 3'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        e = sb.pop_front();
        $display("restart: r1=%h lat=%0d", Result1, c);
        checks++;
        if (!done || c != e.lat || Result1 !== e.r1 || ALUFlags !== e.fl) begin
            errors++;
            $display("FAIL restart_result got done=%b r1=%h f=%b lat=%0d want r1=%h f=%b lat=%0d", done, Result1, ALUFlags, c, e.r1, e.fl, e.lat);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0 || Result1 !== e.r1) begin
            errors++;
            $display("FAIL restart_ignored got extra_dones=%0d r1=%h want 0 dones r1=%h", extra, Result1, e.r1);
        end
    endtask

    task automatic test_reset_abort;
        int   dn;
        exp_t e;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5);
        e = sb.pop_back();
        dn = 0;
        for (int c = 1; c < 10; c++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("abort: busy=%b done=%b r1=%h r2=%h f=%b", busy, done, Result1, Result2, ALUFlags);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (Result1 !== '0 || Result2 !== '0 || ALUFlags !== 4'b0) begin
            errors++;
            $display("FAIL abort_outputs got r1=%h r2=%h f=%b want all 0", Result1, Result2, ALUFlags);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done/busy cycles want 0 (discarded %h)", dn, e.r1);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_multiply();
        test_back_to_back();
        test_busy_restart();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
